riscv_dual_issue_ctrl: RTL and testbench
========================================

Name: riscv_dual_issue_ctrl

Overview:
- Issue controller for the dual-issue core. Accepts a fetched pair {A at fetch_pc, B at fetch_pc+4} together with the first-slot and second-slot decoder outputs.
- Decides whether B may run in the restricted pipe 2 alongside A. If not, B is held and re-issued alone in pipe 1 on the next cycle.
- Owns the registered issue stage that drives both execute pipes.

Parameters:
- PERF_CNT_W, 32, width of the optional statistics counters.

Ports:
- clk  input  1  core clock
- rst_l  input  1  asynchronous reset, active low
- fetch_valid  input  1  fetch pair present
- fetch_ready  output  1  pair consumed this cycle
- fetch_pc  input  32  PC of A
- fetch_inst_a  input  32  instruction A
- fetch_inst_b  input  32  instruction B
- fetch_b_valid  input  1  B slot is a real instruction
- a_rd  input  5  A destination register
- a_writes_rd  input  1  A rd_data_src != RD_NONE
- a_is_ctrl  input  1  A is branch, JAL, JALR or ECALL
- a_except  input  1  A except_ri
- b_rs1  input  5  B source register 1, from the second-slot decoder
- b_rs2  input  5  B source register 2, from the second-slot decoder
- b_rd  input  5  B destination register
- b_writes_rd  input  1  B rd_data_src != RD_NONE
- b_noex  input  1  B pipe_2_noex
- b_except  input  1  B except_ri
- be_ready  input  1  execute stage can accept an issue
- flush  input  1  redirect from execute; kill issue and hold state
- iss1_valid  output  1  pipe 1 issue valid
- iss1_pc  output  32  pipe 1 PC
- iss1_inst  output  32  pipe 1 instruction
- iss2_valid  output  1  pipe 2 issue valid
- iss2_pc  output  32  pipe 2 PC
- iss2_inst  output  32  pipe 2 instruction
- hold_active  output  1  state == HOLD

Behaviour:
- Clocking and reset: single clock. Asynchronous active-low reset on rst_l.
- Reset values: all iss* outputs 0, hold buffer 0, state RUN, hold_active 0. fetch_ready is forced 0 while rst_l is low.
- Hazard terms:
  - dep = a_writes_rd & (a_rd != 0) & ((b_rs1 == a_rd) | (b_rs2 == a_rd)).
  - waw = a_writes_rd & b_writes_rd & (a_rd != 0) & (a_rd == b_rd).
  - pair_ok = fetch_b_valid & !b_noex & !b_except & !a_except & !a_is_ctrl & !dep & !waw.
- fetch_ready = (state == RUN) & be_ready & !flush. This is combinational.
- State RUN, fetch_valid & fetch_ready (update at the clock edge):
  - iss1 <= {1, fetch_pc, A}.
  - If pair_ok: iss2 <= {1, fetch_pc+4, B}; stay in RUN.
  - Else if fetch_b_valid: iss2_valid <= 0; hold <= {fetch_pc+4, B}; go to HOLD.
  - Else: iss2_valid <= 0; stay in RUN.
- State RUN, be_ready & !fetch_valid & !flush: iss1_valid <= 0 and iss2_valid <= 0.
- State HOLD, be_ready & !flush: iss1 <= {1, hold pc, hold inst}; iss2_valid <= 0; go to RUN. The fetch pair is not consumed.
- be_ready = 0 & !flush: all registers hold their values; the iss* outputs stay stable.
- flush = 1: highest priority, including over be_ready = 0. At the next edge iss1_valid = 0, iss2_valid = 0, state = RUN, hold is discarded. No pair is accepted that cycle.
- Latency:
  - A appears on iss1 one edge after the fetch handshake.
  - A split B appears on iss1 exactly one be_ready edge later.
- PC arithmetic: fetch_pc+4 is modulo 2^32 and wraps; 0xFFFF_FFFC yields 0x0000_0000.
- x0 never creates a hazard: a_rd == 0 gives dep = 0 and waw = 0.
- Issue order: pipe 1 always holds the older instruction. iss2_valid implies iss1_valid.

Optional Feature:
- Macro: RISCV_DUAL_ISSUE_STATS_EN.
- When defined, adds output ports stat_pair_cnt, stat_split_cnt and stat_single_cnt, each PERF_CNT_W wide.
  - stat_pair_cnt increments on each pair_ok issue.
  - stat_split_cnt increments on each entry into HOLD.
  - stat_single_cnt increments on each accepted pair with fetch_b_valid = 0.
- Counters reset to 0, saturate at all-ones, and do not count on flush cycles.
- When not defined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Independent pair. A = ADDI x1,x0,5 and B = ADDI x2,x0,7 at pc 0x100, all flags 0. Required: next edge iss1 = {1, 0x100}, iss2 = {1, 0x104}, fetch_ready stays 1, no HOLD.
- RAW split. A = ADD x3,x1,x2 and B = SUB x4,x3,x1 (dep = 1). Required: edge 1 iss1 = A, iss2_valid = 0, hold_active = 1, fetch_ready = 0; edge 2 iss1 = {1, pc+4, B}, state RUN.
- pipe_2_noex split. B = LW with b_noex = 1. Required: same two-cycle split as the RAW case. Separately, a_is_ctrl = 1 (A = BEQ) also forces a split.
- Stall in HOLD. Enter HOLD, then drive be_ready = 0 for 3 cycles. Required: iss1 stays A, hold is kept, fetch_ready = 0; B issues on the first edge after be_ready returns to 1.
- Flush in HOLD with be_ready = 0. Required: next edge iss1_valid = iss2_valid = 0, hold_active = 0, B never issued. x0 check: A = ADDI x0,x0,1 and B = ADD x5,x0,x0 pair normally.
- Reset mid-HOLD by asserting rst_l low asynchronously. Required: outputs clear immediately, without a clock edge. Wrap check: fetch_pc = 0xFFFF_FFFC with pair_ok gives iss2_pc = 0x0000_0000.

Source files
------------

// File: rtl/riscv_dual_issue_ctrl.sv
// rtl/riscv_dual_issue_ctrl.sv - dual-issue pairing decision and registered issue stage
// Optional statistics counters enabled by defining RISCV_DUAL_ISSUE_STATS_EN.
module riscv_dual_issue_ctrl
`ifdef RISCV_DUAL_ISSUE_STATS_EN
  #(parameter int unsigned PERF_CNT_W = 32)
`endif
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst_a,
  input  logic [31:0] fetch_inst_b,
  input  logic        fetch_b_valid,
  input  logic [4:0]  a_rd,
  input  logic        a_writes_rd,
  input  logic        a_is_ctrl,
  input  logic        a_except,
  input  logic [4:0]  b_rs1,
  input  logic [4:0]  b_rs2,
  input  logic [4:0]  b_rd,
  input  logic        b_writes_rd,
  input  logic        b_noex,
  input  logic        b_except,
  input  logic        be_ready,
  input  logic        flush,
  output logic        iss1_valid,
  output logic [31:0] iss1_pc,
  output logic [31:0] iss1_inst,
  output logic        iss2_valid,
  output logic [31:0] iss2_pc,
  output logic [31:0] iss2_inst,
`ifdef RISCV_DUAL_ISSUE_STATS_EN
  output logic [PERF_CNT_W-1:0] stat_pair_cnt,
  output logic [PERF_CNT_W-1:0] stat_split_cnt,
  output logic [PERF_CNT_W-1:0] stat_single_cnt,
`endif
  output logic        hold_active
);

  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        iss1_valid_q, iss1_valid_d;
  logic [31:0] iss1_pc_q, iss1_pc_d;
  logic [31:0] iss1_inst_q, iss1_inst_d;
  logic        iss2_valid_q, iss2_valid_d;
  logic [31:0] iss2_pc_q, iss2_pc_d;
  logic [31:0] iss2_inst_q, iss2_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  logic        dep, waw, pair_ok, accept;
  logic [31:0] pc_b;

  // x0 writes are discarded by the register file, so they never order A before B
  assign dep     = a_writes_rd & (a_rd != 5'd0) & ((b_rs1 == a_rd) | (b_rs2 == a_rd));
  assign waw     = a_writes_rd & b_writes_rd & (a_rd != 5'd0) & (a_rd == b_rd);
  assign pair_ok = fetch_b_valid & ~b_noex & ~b_except & ~a_except & ~a_is_ctrl & ~dep & ~waw;
  assign pc_b    = fetch_pc + 32'd4;

  assign fetch_ready = rst_l & (state_q == RUN) & be_ready & ~flush;
  assign accept      = fetch_valid & fetch_ready;

  always_comb begin
    state_d      = state_q;
    iss1_valid_d = iss1_valid_q;
    iss1_pc_d    = iss1_pc_q;
    iss1_inst_d  = iss1_inst_q;
    iss2_valid_d = iss2_valid_q;
    iss2_pc_d    = iss2_pc_q;
    iss2_inst_d  = iss2_inst_q;
    hold_pc_d    = hold_pc_q;
    hold_inst_d  = hold_inst_q;
    if (flush) begin
      state_d      = RUN;
      iss1_valid_d = 1'b0;
      iss2_valid_d = 1'b0;
      hold_pc_d    = 32'd0;
      hold_inst_d  = 32'd0;
    end else if (be_ready) begin
      case (state_q)
        RUN: begin
          if (fetch_valid) begin
            iss1_valid_d = 1'b1;
            iss1_pc_d    = fetch_pc;
            iss1_inst_d  = fetch_inst_a;
            if (pair_ok) begin
              iss2_valid_d = 1'b1;
              iss2_pc_d    = pc_b;
              iss2_inst_d  = fetch_inst_b;
            end else begin
              iss2_valid_d = 1'b0;
              if (fetch_b_valid) begin
                hold_pc_d   = pc_b;
                hold_inst_d = fetch_inst_b;
                state_d     = HOLD;
              end
            end
          end else begin
            iss1_valid_d = 1'b0;
            iss2_valid_d = 1'b0;
          end
        end
        HOLD: begin
          iss1_valid_d = 1'b1;
          iss1_pc_d    = hold_pc_q;
          iss1_inst_d  = hold_inst_q;
          iss2_valid_d = 1'b0;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= RUN;
      iss1_valid_q <= 1'b0;
      iss1_pc_q    <= 32'd0;
      iss1_inst_q  <= 32'd0;
      iss2_valid_q <= 1'b0;
      iss2_pc_q    <= 32'd0;
      iss2_inst_q  <= 32'd0;
      hold_pc_q    <= 32'd0;
      hold_inst_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      iss1_valid_q <= iss1_valid_d;
      iss1_pc_q    <= iss1_pc_d;
      iss1_inst_q  <= iss1_inst_d;
      iss2_valid_q <= iss2_valid_d;
      iss2_pc_q    <= iss2_pc_d;
      iss2_inst_q  <= iss2_inst_d;
      hold_pc_q    <= hold_pc_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  assign iss1_valid  = iss1_valid_q;
  assign iss1_pc     = iss1_pc_q;
  assign iss1_inst   = iss1_inst_q;
  assign iss2_valid  = iss2_valid_q;
  assign iss2_pc     = iss2_pc_q;
  assign iss2_inst   = iss2_inst_q;
  assign hold_active = (state_q == HOLD);

`ifdef RISCV_DUAL_ISSUE_STATS_EN
  logic [PERF_CNT_W-1:0] pair_cnt_q, split_cnt_q, single_cnt_q;

  // accept already excludes flush cycles; counters stick at all-ones
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pair_cnt_q   <= '0;
      split_cnt_q  <= '0;
      single_cnt_q <= '0;
    end else if (accept) begin
      if (pair_ok && (pair_cnt_q != '1))
        pair_cnt_q <= pair_cnt_q + 1'b1;
      if (!pair_ok && fetch_b_valid && (split_cnt_q != '1))
        split_cnt_q <= split_cnt_q + 1'b1;
      if (!fetch_b_valid && (single_cnt_q != '1))
        single_cnt_q <= single_cnt_q + 1'b1;
    end
  end

  assign stat_pair_cnt   = pair_cnt_q;
  assign stat_split_cnt  = split_cnt_q;
  assign stat_single_cnt = single_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_dual_issue_ctrl.sv
// tb/tb_riscv_dual_issue_ctrl.sv - directed self-checking bench for riscv_dual_issue_ctrl
module tb_riscv_dual_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc, fetch_inst_a, fetch_inst_b;
  logic        fetch_b_valid;
  logic [4:0]  a_rd, b_rs1, b_rs2, b_rd;
  logic        a_writes_rd, a_is_ctrl, a_except;
  logic        b_writes_rd, b_noex, b_except;
  logic        be_ready, flush;
  logic        iss1_valid, iss2_valid, hold_active;
  logic [31:0] iss1_pc, iss1_inst, iss2_pc, iss2_inst;
`ifdef RISCV_DUAL_ISSUE_STATS_EN
  logic [31:0] stat_pair_cnt, stat_split_cnt, stat_single_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] ADDI_X2 = 32'h0070_0113;
  localparam logic [31:0] ADD_X3  = 32'h0020_81B3;
  localparam logic [31:0] SUB_X4  = 32'h4011_8233;
  localparam logic [31:0] LW_X6   = 32'h0001_2303;
  localparam logic [31:0] BEQ_X0  = 32'h0000_0063;
  localparam logic [31:0] ADDI_X0 = 32'h0010_0013;
  localparam logic [31:0] ADD_X5  = 32'h0000_02B3;

  riscv_dual_issue_ctrl dut (
    .clk(clk), .rst_l(rst_l),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_inst_a(fetch_inst_a), .fetch_inst_b(fetch_inst_b),
    .fetch_b_valid(fetch_b_valid),
    .a_rd(a_rd), .a_writes_rd(a_writes_rd), .a_is_ctrl(a_is_ctrl), .a_except(a_except),
    .b_rs1(b_rs1), .b_rs2(b_rs2), .b_rd(b_rd), .b_writes_rd(b_writes_rd),
    .b_noex(b_noex), .b_except(b_except),
    .be_ready(be_ready), .flush(flush),
    .iss1_valid(iss1_valid), .iss1_pc(iss1_pc), .iss1_inst(iss1_inst),
    .iss2_valid(iss2_valid), .iss2_pc(iss2_pc), .iss2_inst(iss2_inst),
`ifdef RISCV_DUAL_ISSUE_STATS_EN
    .stat_pair_cnt(stat_pair_cnt), .stat_split_cnt(stat_split_cnt),
    .stat_single_cnt(stat_single_cnt),
`endif
    .hold_active(hold_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pair(input logic [31:0] pc, input logic [31:0] ia, input logic [31:0] ib,
                          input logic bv, input logic [4:0] ard, input logic awr,
                          input logic actl, input logic [4:0] brs1, input logic [4:0] brs2,
                          input logic [4:0] brd, input logic bwr, input logic bnx);
    fetch_pc      = pc;
    fetch_inst_a  = ia;
    fetch_inst_b  = ib;
    fetch_b_valid = bv;
    a_rd          = ard;
    a_writes_rd   = awr;
    a_is_ctrl     = actl;
    a_except      = 1'b0;
    b_rs1         = brs1;
    b_rs2         = brs2;
    b_rd          = brd;
    b_writes_rd   = bwr;
    b_noex        = bnx;
    b_except      = 1'b0;
    fetch_valid   = 1'b1;
  endtask

  // Drives a pair known to split, then checks the two-edge split sequence
  task automatic split_case(input string tag, input logic [31:0] pc, input logic [31:0] ib);
    step();
    fetch_valid = 1'b0;
    check({tag, "_e1_iss1_pc"}, 64'(iss1_pc), 64'(pc));
    check({tag, "_e1_iss2_v"}, 64'(iss2_valid), 64'd0);
    check({tag, "_e1_hold"}, 64'(hold_active), 64'd1);
    check({tag, "_e1_frdy"}, 64'(fetch_ready), 64'd0);
    step();
    check({tag, "_e2_iss1"}, {31'd0, iss1_valid, iss1_pc}, {31'd0, 1'b1, pc + 32'd4});
    check({tag, "_e2_inst"}, 64'(iss1_inst), 64'(ib));
    check({tag, "_e2_hold"}, 64'(hold_active), 64'd0);
  endtask

  initial begin
    rst_l = 1'b0;
    fetch_valid = 1'b0;
    be_ready = 1'b1;
    flush = 1'b0;
    set_pair(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    fetch_valid = 1'b0;
    #1;
    check("rst_frdy", 64'(fetch_ready), 64'd0);
    step();
    check("rst_iss", {iss1_valid, iss2_valid, hold_active}, 64'd0);
    check("rst_pc", 64'(iss1_pc), 64'd0);
    rst_l = 1'b1;
    #1;
    check("run_frdy", 64'(fetch_ready), 64'd1);

    // independent pair
    set_pair(32'h100, ADDI_X1, ADDI_X2, 1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd7, 5'd2, 1'b1, 1'b0);
    step();
    fetch_valid = 1'b0;
    check("pair_iss1", {31'd0, iss1_valid, iss1_pc}, {31'd0, 1'b1, 32'h100});
    check("pair_iss2", {31'd0, iss2_valid, iss2_pc}, {31'd0, 1'b1, 32'h104});
    check("pair_inst", {iss1_inst, iss2_inst}, {ADDI_X1, ADDI_X2});
    check("pair_hold", {hold_active, fetch_ready}, 64'b01);
    step();
    check("idle_valid", {iss1_valid, iss2_valid}, 64'd0);

    set_pair(32'h200, ADD_X3, SUB_X4, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0);
    split_case("raw", 32'h200, SUB_X4);
    set_pair(32'h300, ADDI_X1, LW_X6, 1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd6, 1'b1, 1'b1);
    split_case("noex", 32'h300, LW_X6);
    set_pair(32'h400, BEQ_X0, ADDI_X2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 5'd7, 5'd2, 1'b1, 1'b0);
    split_case("ctrl", 32'h400, ADDI_X2);
    set_pair(32'h800, ADDI_X1, ADDI_X1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd5 ^ 5'd1, 5'd5, 1'b1, 1'b0);
    split_case("waw", 32'h800, ADDI_X1);

    // stall in HOLD
    set_pair(32'h500, ADD_X3, SUB_X4, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0);
    step();
    fetch_valid = 1'b0;
    be_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_iss1", {31'd0, iss1_valid, iss1_pc}, {31'd0, 1'b1, 32'h500});
      check("stall_hold", {hold_active, fetch_ready}, 64'b10);
    end
    be_ready = 1'b1;
    step();
    check("stall_b", {31'd0, iss1_valid, iss1_pc}, {31'd0, 1'b1, 32'h504});
    check("stall_run", 64'(hold_active), 64'd0);

    // flush in HOLD overriding be_ready = 0
    set_pair(32'h600, ADD_X3, SUB_X4, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0);
    step();
    fetch_valid = 1'b0;
    be_ready = 1'b0;
    flush = 1'b1;
    step();
    check("flush_valid", {iss1_valid, iss2_valid, hold_active}, 64'd0);
    flush = 1'b0;
    be_ready = 1'b1;
    step();
    check("flush_noB", 64'(iss1_valid), 64'd0);

    // x0 destination on A never creates a hazard
    set_pair(32'h700, ADDI_X0, ADD_X5, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    step();
    fetch_valid = 1'b0;
    check("x0_iss2", {31'd0, iss2_valid, iss2_pc}, {31'd0, 1'b1, 32'h704});
    check("x0_hold", 64'(hold_active), 64'd0);

    // single instruction, no B
    set_pair(32'h900, ADDI_X1, ADDI_X2, 1'b0, 5'd1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    fetch_valid = 1'b0;
    check("single", {iss1_valid, iss2_valid, hold_active}, 64'b100);

    // asynchronous reset while in HOLD
    set_pair(32'hA00, ADD_X3, SUB_X4, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0);
    step();
    fetch_valid = 1'b0;
    check("areset_pre", 64'(hold_active), 64'd1);
    #2 rst_l = 1'b0;
    #1;
    check("areset_out", {iss1_valid, iss2_valid, hold_active, fetch_ready}, 64'd0);
    check("areset_pc", 64'(iss1_pc), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // PC wrap on B
    set_pair(32'hFFFF_FFFC, ADDI_X1, ADDI_X2, 1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd7, 5'd2, 1'b1, 1'b0);
    step();
    fetch_valid = 1'b0;
    check("wrap_iss2", {31'd0, iss2_valid, iss2_pc}, {31'd0, 1'b1, 32'h0});
    check("wrap_iss1", 64'(iss1_pc), 64'hFFFF_FFFC);
`ifdef RISCV_DUAL_ISSUE_STATS_EN
    check("stat_pair", 64'(stat_pair_cnt), 64'd1);
    check("stat_split", 64'(stat_split_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
